spi_slave_rx_mode1: RTL and testbench
=====================================

# spi_slave_rx_mode1

SPI slave receiver for SPI mode 1 (CPOL=0, CPHA=1), 8-bit MSB-first words. It is the far end of the team's mode-1 SPI master transmitter. It oversamples the external CS_N/SCLK/MOSI pins with In_clk, samples MOSI on each SCLK falling edge, and presents completed bytes on a valid/ready output with one holding register. It flags overrun and truncated-frame errors.

## Interface
- SYNC_STAGES, 2, depth of the pin synchronizer flops on CS_N, SCLK and MOSI. Legal values are 2 or more.
- In_clk  input  1  system clock; all logic is on its rising edge
- In_rst_n  input  1  asynchronous active-low reset
- In_spi_cs_n  input  1  chip select from master, active low, asynchronous to In_clk
- In_spi_sclk  input  1  SPI clock from master, idles low, asynchronous
- In_spi_mosi  input  1  serial data from master, asynchronous
- In_rx_ready  input  1  consumer accepts Out_rx_data in any cycle where Out_rx_valid=1
- Out_rx_data  output  8  last completed byte; bit 7 is the first bit received
- Out_rx_valid  output  1  Out_rx_data holds an unconsumed byte
- Out_rx_busy  output  1  high while a frame is active (synchronized CS_N low, ACTIVE state)
- Out_rx_overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being read
- Out_frame_err  output  1  one-cycle pulse: CS_N deasserted with a partial byte (1–7 bits) received

## Operation
- Synchronizers: each pin passes through a SYNC_STAGES flop chain. Reset values are cs_n=1, sclk=0, mosi=0. One extra register per signal on cs_n and sclk provides edge detection: cs_fall, cs_rise, sclk_fall. All three pins use the same depth, so MOSI stays aligned with SCLK.
- State machine: IDLE and ACTIVE.
  - IDLE → ACTIVE only on cs_fall. bit_cnt=0 and the shift register is cleared.
  - ACTIVE → IDLE on cs_rise. If bit_cnt≠0, pulse Out_frame_err and discard the partial byte. bit_cnt returns to 0.
  - If CS_N is already low when reset releases, the block does not enter ACTIVE. That frame is ignored until CS_N goes high and then low again.
- Bit capture: in ACTIVE, on sclk_fall with synchronized cs_n=0, do shift = {shift[6:0], mosi_sync} and bit_cnt += 1.
- SCLK edges while cs_n is high are ignored. This includes an sclk_fall in the same cycle as cs_rise.
- SCLK rising edges are not used.
- Byte completion: this is the sclk_fall where bit_cnt==7. Call the completed byte {shift[6:0], mosi_sync}. bit_cnt wraps to 0 and the block stays in ACTIVE, so multiple bytes per CS frame are supported.
- Holding register rules:
  - On completion with Out_rx_valid=0, or with Out_rx_valid=1 and In_rx_ready=1: load Out_rx_data and set Out_rx_valid=1. No overrun.
  - On completion with Out_rx_valid=1 and In_rx_ready=0: keep the old byte, discard the new byte, and pulse Out_rx_overrun.
  - With no completion: if Out_rx_valid=1 and In_rx_ready=1, clear Out_rx_valid.
- Out_rx_data changes only when it is loaded. It keeps its value after Out_rx_valid clears.
- Reset values: Out_rx_data=8'h00, Out_rx_valid=0, Out_rx_busy=0, Out_rx_overrun=0, Out_frame_err=0. Also state=IDLE, bit_cnt=0, shift=0.
- Reset asserted mid-frame: all state clears immediately and no partial byte or error is reported.

## Timing
- SCLK high and low phases must each be at least 2 In_clk periods. Recommended In_clk/SCLK ratio is 8 or more; nominal is 50 MHz / 50 kHz.
- MOSI must be stable from at least 1 In_clk before to 1 In_clk after the SCLK falling edge.
- Latency from the 8th SCLK falling edge at the pin to Out_rx_valid high is SYNC_STAGES+1 In_clk cycles, with +1 cycle pin-sampling uncertainty.
- Out_rx_busy rises SYNC_STAGES+1 cycles after the CS_N pin falls, and falls the same delay after CS_N rises.
- Out_frame_err asserts in the same cycle Out_rx_busy falls, for exactly 1 cycle.
- Out_rx_overrun asserts for 1 cycle, in the cycle where Out_rx_valid would otherwise have been loaded.
- Handshake: a transfer occurs on a clock edge where Out_rx_valid=1 and In_rx_ready=1. Back-to-back bytes need no idle cycles because the load and the consume can happen in the same cycle.

## Test plan
- Single byte, In_rx_ready=1, master sends 0xA5 → Out_rx_valid high for 1 cycle with Out_rx_data=0xA5, SYNC_STAGES+1(±1) cycles after the 8th SCLK fall. No error pulses. Out_rx_busy tracks CS_N.
- Two bytes 0x3C then 0xC3 in one CS frame, In_rx_ready=1 → two valid pulses, data 0x3C then 0xC3. Out_rx_busy stays high between the bytes.
- Overrun: In_rx_ready=0, send 0x11 then 0x22 → Out_rx_data=0x11 with valid held and exactly one Out_rx_overrun pulse. Then raise ready → valid clears after one transfer of 0x11.
- Truncated frame: deassert CS_N after 5 bits → one Out_frame_err pulse and no valid. The next frame sends 0x5A → received correctly.
- Reset mid-frame: assert In_rst_n low after 3 bits and release with CS_N still low, while the master finishes that byte and sends 0x77 → no valid and no error. After CS_N goes high then low, 0xFF is received correctly.
- Clock-ratio stress with In_clk/SCLK=8, 256-byte frame of values 0x00..0xFF, ready always 1 → all bytes received in order and no overrun.

Source files
------------

// File: rtl/spi_slave_rx_mode1.sv
// SPI mode-1 (CPOL=0, CPHA=1) slave receiver: oversampled pins, MSB-first byte
// capture on SCLK falling edges, one holding register with overrun/frame-error pulses.
module spi_slave_rx_mode1 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       In_clk,
    input  logic       In_rst_n,
    input  logic       In_spi_cs_n,
    input  logic       In_spi_sclk,
    input  logic       In_spi_mosi,
    input  logic       In_rx_ready,
    output logic [7:0] Out_rx_data,
    output logic       Out_rx_valid,
    output logic       Out_rx_busy,
    output logic       Out_rx_overrun,
    output logic       Out_frame_err
);
    localparam int FILL_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] csSync_q, sclkSync_q, mosiSync_q;
    logic                   csPrev_q, sclkPrev_q;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frameErr_q, frameErr_d;

    logic       csS, sclkS, mosiS;
    logic       edgesEn, csFall, csRise, sclkFall;
    logic       capture, complete;
    logic [7:0] newByte;

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            csSync_q   <= '1;
            sclkSync_q <= '0;
            mosiSync_q <= '0;
            csPrev_q   <= 1'b1;
            sclkPrev_q <= 1'b0;
            fill_q     <= '0;
        end else begin
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], In_spi_cs_n};
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], In_spi_sclk};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], In_spi_mosi};
            csPrev_q   <= csS;
            sclkPrev_q <= sclkS;
            fill_q     <= fill_d;
        end
    end

    // Edges are suppressed until the chains hold real pin samples, so a CS_N
    // already low at reset release is not mistaken for a falling edge.
    always_comb begin
        csS      = csSync_q[SYNC_STAGES-1];
        sclkS    = sclkSync_q[SYNC_STAGES-1];
        mosiS    = mosiSync_q[SYNC_STAGES-1];
        edgesEn  = (fill_q == FILL_DONE);
        fill_d   = edgesEn ? fill_q : fill_q + 1'b1;
        csFall   = edgesEn & csPrev_q & ~csS;
        csRise   = edgesEn & ~csPrev_q & csS;
        sclkFall = edgesEn & sclkPrev_q & ~sclkS;
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csFall) state_d = ACTIVE;
            ACTIVE:  if (csRise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Out_rx_busy = (state_q == ACTIVE);
    end

    always_comb begin
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        frameErr_d = 1'b0;
        capture    = (state_q == ACTIVE) && sclkFall && !csS;
        complete   = capture && (bitCnt_q == 3'd7);
        newByte    = {shift_q[6:0], mosiS};

        if (state_q == IDLE && csFall) begin
            bitCnt_d = '0;
            shift_d  = '0;
        end else if (state_q == ACTIVE && csRise) begin
            bitCnt_d   = '0;
            frameErr_d = (bitCnt_q != 3'd0);
        end else if (capture) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 3'd1;
        end

        if (complete) begin
            if (!valid_q || In_rx_ready) begin
                data_d  = newByte;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && In_rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            bitCnt_q   <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign Out_rx_data    = data_q;
    assign Out_rx_valid   = valid_q;
    assign Out_rx_overrun = overrun_q;
    assign Out_frame_err  = frameErr_q;

endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
// Directed + randomized bench for spi_slave_rx_mode1; expected byte stream and
// error counts come from a frame-level model (whole bytes sent => bytes received).
module tb_spi_slave_rx_mode1;
    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       csN = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] rxData;
    logic       rxValid, rxBusy, rxOverrun, frameErr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lastFallCyc = 0;

    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int overrunCnt = 0, errCnt = 0, errMisaligned = 0, validCycles = 0, validRiseCyc = 0;
    int expOverrun = 0, expErr = 0;
    logic prevBusy = 1'b0, prevValid = 1'b0;

    spi_slave_rx_mode1 #(.SYNC_STAGES(SYNC)) dut (
        .In_clk        (clk),
        .In_rst_n      (rstN),
        .In_spi_cs_n   (csN),
        .In_spi_sclk   (sclk),
        .In_spi_mosi   (mosi),
        .In_rx_ready   (ready),
        .Out_rx_data   (rxData),
        .Out_rx_valid  (rxValid),
        .Out_rx_busy   (rxBusy),
        .Out_rx_overrun(rxOverrun),
        .Out_frame_err (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Mid-cycle observer: a transfer is any cycle with valid and ready both high.
    always @(negedge clk) begin
        if (rstN) begin
            if (rxValid && ready) rxQ.push_back(rxData);
            if (rxValid) validCycles++;
            if (rxValid && !prevValid) validRiseCyc = cyc;
            if (rxOverrun) overrunCnt++;
            if (frameErr) begin
                errCnt++;
                if (rxBusy || !prevBusy) errMisaligned++;
            end
        end
        prevBusy  = rxBusy;
        prevValid = rxValid;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends the top nbits of b, MSB first; MOSI changes on the leading (rising) edge.
    task automatic applyStimulus(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = b[7-i];
            waitClk(HALF);
            sclk = 1'b0;
            lastFallCyc = cyc;
            waitClk(HALF);
        end
    endtask

    task automatic csLow();
        csN = 1'b0;
        waitClk(HALF);
    endtask

    task automatic csHigh();
        waitClk(HALF);
        csN = 1'b1;
        waitClk(8);
    endtask

    task automatic checkStream(input string tag);
        int mism;
        int n;
        mism = 0;
        n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
        for (int i = 0; i < n; i++) if (rxQ[i] !== expQ[i]) mism++;
        checkOutput({tag, "_count"}, rxQ.size(), expQ.size());
        checkOutput({tag, "_data"}, mism, 0);
        checkOutput({tag, "_overruns"}, overrunCnt, expOverrun);
        checkOutput({tag, "_frame_errs"}, errCnt, expErr);
    endtask

    initial begin
        int lat, v0, nb, n;
        logic [7:0] d;

        waitClk(3);
        checkOutput("reset_data", rxData, 8'h00);
        checkOutput("reset_valid", rxValid, 1'b0);
        checkOutput("reset_busy", rxBusy, 1'b0);
        checkOutput("reset_overrun", rxOverrun, 1'b0);
        checkOutput("reset_frame_err", frameErr, 1'b0);
        rstN = 1'b1;
        waitClk(6);

        v0 = validCycles;
        csN = 1'b0;
        waitClk(SYNC);
        checkOutput("busy_rise_early", rxBusy, 1'b0);
        waitClk(1);
        checkOutput("busy_rise", rxBusy, 1'b1);
        waitClk(HALF);
        applyStimulus(8'hA5, 8);
        expQ.push_back(8'hA5);
        lat = validRiseCyc - lastFallCyc;
        checkOutput("a5_latency_in_window", (lat >= SYNC + 1 && lat <= SYNC + 2), 1'b1);
        checkOutput("a5_valid_one_cycle", validCycles - v0, 1);
        waitClk(HALF);
        csN = 1'b1;
        waitClk(SYNC);
        checkOutput("busy_fall_early", rxBusy, 1'b1);
        waitClk(1);
        checkOutput("busy_fall", rxBusy, 1'b0);
        waitClk(6);
        checkStream("single_a5");

        csLow();
        applyStimulus(8'h3C, 8);
        checkOutput("busy_between_bytes", rxBusy, 1'b1);
        applyStimulus(8'hC3, 8);
        expQ.push_back(8'h3C);
        expQ.push_back(8'hC3);
        csHigh();
        checkStream("two_bytes");

        ready = 1'b0;
        csLow();
        applyStimulus(8'h11, 8);
        applyStimulus(8'h22, 8);
        csHigh();
        expOverrun++;
        checkOutput("overrun_held_data", rxData, 8'h11);
        checkOutput("overrun_held_valid", rxValid, 1'b1);
        ready = 1'b1;
        expQ.push_back(8'h11);
        waitClk(2);
        checkOutput("overrun_drained_valid", rxValid, 1'b0);
        checkStream("overrun");

        csLow();
        applyStimulus(8'hE8, 5);
        csHigh();
        expErr++;
        checkStream("truncated");
        csLow();
        applyStimulus(8'h5A, 8);
        expQ.push_back(8'h5A);
        csHigh();
        checkStream("after_truncated");

        csLow();
        applyStimulus(8'h77, 3);
        rstN = 1'b0;
        waitClk(2);
        checkOutput("midreset_valid", rxValid, 1'b0);
        checkOutput("midreset_busy", rxBusy, 1'b0);
        rstN = 1'b1;
        waitClk(2);
        applyStimulus(8'hB8, 5);
        applyStimulus(8'h77, 8);
        checkOutput("ignored_frame_busy", rxBusy, 1'b0);
        csHigh();
        checkStream("ignored_frame");
        csLow();
        applyStimulus(8'hFF, 8);
        expQ.push_back(8'hFF);
        csHigh();
        checkStream("after_midreset");

        csLow();
        for (int v = 0; v < 256; v++) begin
            applyStimulus(8'(v), 8);
            expQ.push_back(8'(v));
        end
        csHigh();
        checkStream("stress_256");

        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 24);
            csLow();
            for (int j = 0; j * 8 < nb; j++) begin
                d = 8'($urandom);
                n = (nb - j * 8 > 8) ? 8 : nb - j * 8;
                applyStimulus(d, n);
                if (n == 8) expQ.push_back(d);
            end
            if (nb % 8 != 0) expErr++;
            csHigh();
            checkStream("random_frame");
        end

        checkOutput("frame_err_with_busy_fall", errMisaligned, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
